// File: rtl/pause_pkg.sv
// Shared definitions for the pause / screen-dim controller.
//   state_e   : top-level pause FSM encoding (RUN, PAUSED, STEP)
//   width_for : number of bits needed to hold values 0..max_val,
//               used to size the dim timer and the dim-level output
package pause_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        STEP   = 2'd2
    } state_e;

    // Equivalent to $clog2(max_val + 1), never smaller than one bit.
    function automatic int width_for(input longint max_val);
        int     w;
        longint one;
        w   = 1;
        one = 64'sd1;
        for (int i = 1; i < 63; i++) begin
            if ((one << i) <= max_val) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pause_dim_ctl_if.sv
// Video stream bundle between the game core and the video pipeline.
//   vblank         : core vertical blank (drives single-frame step)
//   r_in/g_in/b_in : core pixel, into the dimmer
//   r_out/g_out/b_out : dimmed pixel, towards arcade_video
// master = core / pipeline side, slave = pause_dim_ctl.
interface pause_dim_ctl_if #(
    parameter int RW = 3,
    parameter int GW = 3,
    parameter int BW = 2
);
    logic          vblank;
    logic [RW-1:0] r_in;
    logic [GW-1:0] g_in;
    logic [BW-1:0] b_in;
    logic [RW-1:0] r_out;
    logic [GW-1:0] g_out;
    logic [BW-1:0] b_out;

    modport master (
        output vblank, r_in, g_in, b_in,
        input  r_out, g_out, b_out
    );

    modport slave (
        input  vblank, r_in, g_in, b_in,
        output r_out, g_out, b_out
    );
endinterface

// File: rtl/rgb_dimmer.sv
// Registered per-channel dimmer. Each colour channel is shifted right by
// `level` on its own with zero fill, so no channel bleeds into another.
//   clk, reset_n        : clock, async active-low reset (outputs clear to 0)
//   level               : right-shift amount, 0 = pass-through
//   r_in/g_in/b_in      : input pixel
//   r_out/g_out/b_out   : shifted pixel, one clock of latency
module rgb_dimmer #(
    parameter int RW = 3,
    parameter int GW = 3,
    parameter int BW = 2,
    parameter int LW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [LW-1:0] level,
    input  logic [RW-1:0] r_in,
    input  logic [GW-1:0] g_in,
    input  logic [BW-1:0] b_in,
    output logic [RW-1:0] r_out,
    output logic [GW-1:0] g_out,
    output logic [BW-1:0] b_out
);

    logic [RW-1:0] r_d, r_q;
    logic [GW-1:0] g_d, g_q;
    logic [BW-1:0] b_d, b_q;

    // Shift each channel independently by the requested level.
    always_comb begin
        r_d = r_in >> level;
        g_d = g_in >> level;
        b_d = b_in >> level;
    end

    // Pixel output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
        end
    end

    assign r_out = r_q;
    assign g_out = g_q;
    assign b_out = b_q;

endmodule

// File: rtl/pause_dim_ctl.sv
// Pause and screen-dim controller for arcade cores.
// Merges the user pause toggle, OSD auto-pause, external hold requests and
// a single-frame step into one registered `pause`, and dims the pixel
// stream after a long user/OSD pause.
//   clk, reset_n    : clk_sys, async active-low reset
//   pause_btn       : pause toggle button (rising edge acts)
//   step_btn        : frame-advance button (rising edge acts while paused)
//   osd_status      : OSD open
//   cfg_osd_pause   : auto-pause while the OSD is open
//   cfg_dim_en      : enable dimming
//   hold_req        : external level-sensitive pause holds
//   pause           : pause to the core (registered)
//   user_paused     : user toggle state, PAUSED or STEP
//   dim_level       : current right-shift applied to the pixel
//   vid             : vblank + pixel in / dimmed pixel out
module pause_dim_ctl
    import pause_pkg::*;
#(
    parameter int RW          = 3,
    parameter int GW          = 3,
    parameter int BW          = 2,
    parameter int N_HOLD      = 1,
    parameter int DIM_CYCLES  = 240000000,
    parameter int STEP_CYCLES = 12000000,
    parameter int MAX_SHIFT   = 2,
    localparam int LW = width_for(longint'(MAX_SHIFT))
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pause_btn,
    input  logic              step_btn,
    input  logic              osd_status,
    input  logic              cfg_osd_pause,
    input  logic              cfg_dim_en,
    input  logic [N_HOLD-1:0] hold_req,
    output logic              pause,
    output logic              user_paused,
    output logic [LW-1:0]     dim_level,
    pause_dim_ctl_if.slave    vid
);

    localparam int CW = width_for(longint'((DIM_CYCLES > STEP_CYCLES) ? DIM_CYCLES : STEP_CYCLES));
    localparam logic [CW-1:0] DIM_LAST  = CW'(DIM_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [LW-1:0] MAX_LVL   = LW'(MAX_SHIFT);

    state_e        state_d, state_q;
    logic          pause_hist_d, pause_hist_q;
    logic          step_hist_d, step_hist_q;
    logic          vblank_hist_d, vblank_hist_q;
    logic          pause_rise_d, pause_rise_q;
    logic          step_rise_d, step_rise_q;
    logic          vblank_rise_d, vblank_rise_q;
    logic          pause_d, pause_q;
    logic          user_paused_d, user_paused_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [LW-1:0] dim_d, dim_q;
    logic          osd_p_s;
    logic          dim_cond_s;

    assign osd_p_s    = osd_status & cfg_osd_pause;
    // Holds and STEP never count towards dimming; OSD pause does.
    assign dim_cond_s = ((state_q == PAUSED) | osd_p_s) & cfg_dim_en;

    // Rising-edge detectors: the event is available one clock after the rise.
    always_comb begin
        pause_hist_d  = pause_btn;
        step_hist_d   = step_btn;
        vblank_hist_d = vid.vblank;
        pause_rise_d  = pause_btn & ~pause_hist_q;
        step_rise_d   = step_btn & ~step_hist_q;
        vblank_rise_d = vid.vblank & ~vblank_hist_q;
    end

    // Pause FSM next state; a pause toggle beats step and vblank events.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (pause_rise_q) begin
                    state_d = PAUSED;
                end else begin
                    state_d = RUN;
                end
            end
            PAUSED: begin
                if (pause_rise_q) begin
                    state_d = RUN;
                end else if (step_rise_q) begin
                    state_d = STEP;
                end else begin
                    state_d = PAUSED;
                end
            end
            STEP: begin
                if (pause_rise_q) begin
                    state_d = RUN;
                end else if (vblank_rise_q) begin
                    state_d = PAUSED;
                end else begin
                    state_d = STEP;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Merged pause and user-visible toggle state.
    always_comb begin
        pause_d       = (state_q == PAUSED) | osd_p_s | (|hold_req);
        user_paused_d = (state_d != RUN);
    end

    // Dim timer: DIM_CYCLES to the first level, then STEP_CYCLES per level,
    // holding once MAX_SHIFT is reached. Dropping the condition clears both.
    always_comb begin
        cnt_d = cnt_q;
        dim_d = dim_q;
        if (!dim_cond_s) begin
            cnt_d = '0;
            dim_d = '0;
        end else if (dim_q == '0) begin
            if (cnt_q == DIM_LAST) begin
                cnt_d = '0;
                dim_d = LW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (dim_q < MAX_LVL) begin
            if (cnt_q == STEP_LAST) begin
                cnt_d = '0;
                dim_d = dim_q + LW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
            dim_d = dim_q;
        end
    end

    // State, edge history, timer and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            pause_hist_q  <= 1'b0;
            step_hist_q   <= 1'b0;
            vblank_hist_q <= 1'b0;
            pause_rise_q  <= 1'b0;
            step_rise_q   <= 1'b0;
            vblank_rise_q <= 1'b0;
            pause_q       <= 1'b0;
            user_paused_q <= 1'b0;
            cnt_q         <= '0;
            dim_q         <= '0;
        end else begin
            state_q       <= state_d;
            pause_hist_q  <= pause_hist_d;
            step_hist_q   <= step_hist_d;
            vblank_hist_q <= vblank_hist_d;
            pause_rise_q  <= pause_rise_d;
            step_rise_q   <= step_rise_d;
            vblank_rise_q <= vblank_rise_d;
            pause_q       <= pause_d;
            user_paused_q <= user_paused_d;
            cnt_q         <= cnt_d;
            dim_q         <= dim_d;
        end
    end

    assign pause       = pause_q;
    assign user_paused = user_paused_q;
    assign dim_level   = dim_q;

    // The dimmer takes the level being loaded this clock, so an unpause
    // undims the very pixel registered alongside the cleared level.
    rgb_dimmer #(
        .RW (RW),
        .GW (GW),
        .BW (BW),
        .LW (LW)
    ) u_dimmer (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (dim_d),
        .r_in    (vid.r_in),
        .g_in    (vid.g_in),
        .b_in    (vid.b_in),
        .r_out   (vid.r_out),
        .g_out   (vid.g_out),
        .b_out   (vid.b_out)
    );

endmodule

// File: tb/tb_pause_dim_ctl.sv
// Scoreboard bench for pause_dim_ctl: a behavioural model pushes the
// expected outputs for every clock, a monitor pops and compares them.
module tb_pause_dim_ctl;

    localparam int DIM   = 100;
    localparam int STEPC = 10;
    localparam int MAXS  = 2;

    localparam int M_RUN   = 0;
    localparam int M_PAUSE = 1;
    localparam int M_STEP  = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       pause_btn = 1'b0;
    logic       step_btn = 1'b0;
    logic       osd_status = 1'b0;
    logic       cfg_osd_pause = 1'b0;
    logic       cfg_dim_en = 1'b1;
    logic [1:0] hold_req = 2'b00;
    logic       pause;
    logic       user_paused;
    logic [1:0] dim_level;

    pause_dim_ctl_if #(.RW(3), .GW(3), .BW(2)) vif ();

    pause_dim_ctl #(
        .RW(3), .GW(3), .BW(2), .N_HOLD(2),
        .DIM_CYCLES(DIM), .STEP_CYCLES(STEPC), .MAX_SHIFT(MAXS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pause_btn     (pause_btn),
        .step_btn      (step_btn),
        .osd_status    (osd_status),
        .cfg_osd_pause (cfg_osd_pause),
        .cfg_dim_en    (cfg_dim_en),
        .hold_req      (hold_req),
        .pause         (pause),
        .user_paused   (user_paused),
        .dim_level     (dim_level),
        .vid           (vif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       p;
        logic       u;
        logic [1:0] d;
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: mode, pending button events and paused-time count.
    initial begin
        int   mode, old_mode, k, nd;
        bit   ev_p, ev_s, ev_v, prev_p, prev_s, prev_v, osdp;
        exp_t e;
        mode = M_RUN; k = 0;
        ev_p = 0; ev_s = 0; ev_v = 0; prev_p = 0; prev_s = 0; prev_v = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mode = M_RUN; k = 0;
                ev_p = 0; ev_s = 0; ev_v = 0; prev_p = 0; prev_s = 0; prev_v = 0;
                sb.delete();
            end else begin
                old_mode = mode;
                if (ev_p) mode = (mode == M_RUN) ? M_PAUSE : M_RUN;
                else if (ev_s && mode == M_PAUSE) mode = M_STEP;
                else if (ev_v && mode == M_STEP) mode = M_PAUSE;
                osdp = osd_status && cfg_osd_pause;
                if ((old_mode == M_PAUSE || osdp) && cfg_dim_en) k = k + 1;
                else k = 0;
                if (k < DIM) nd = 0;
                else nd = 1 + (k - DIM) / STEPC;
                if (nd > MAXS) nd = MAXS;
                e.p = (old_mode == M_PAUSE) || osdp || (hold_req != 2'b00);
                e.u = (mode != M_RUN);
                e.d = 2'(nd);
                e.r = vif.r_in >> nd;
                e.g = vif.g_in >> nd;
                e.b = vif.b_in >> nd;
                sb.push_back(e);
                ev_p = pause_btn && !prev_p;
                ev_s = step_btn && !prev_s;
                ev_v = vif.vblank && !prev_v;
                prev_p = pause_btn; prev_s = step_btn; prev_v = vif.vblank;
            end
        end
    end

    // Monitor: compare every clock's outputs against the model.
    initial begin
        exp_t act, e;
        forever begin
            @(negedge clk);
            act = {pause, user_paused, dim_level, vif.r_out, vif.g_out, vif.b_out};
            if (!reset_n || sb.size() > 0) begin
                if (!reset_n) e = '0;
                else e = sb.pop_front();
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t got p=%0b u=%0b d=%0d rgb=%0d/%0d/%0d want p=%0b u=%0b d=%0d rgb=%0d/%0d/%0d",
                             $time, act.p, act.u, act.d, act.r, act.g, act.b,
                             e.p, e.u, e.d, e.r, e.g, e.b);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_pause();
        pause_btn = 1'b1;
        tick(1);
        pause_btn = 1'b0;
    endtask

    task automatic pulse_step();
        step_btn = 1'b1;
        tick(1);
        step_btn = 1'b0;
    endtask

    initial begin
        vif.vblank = 1'b0;
        vif.r_in = 3'd7; vif.g_in = 3'd5; vif.b_in = 2'd3;
        #2 reset_n = 1'b0;
        #1 chk("reset_pause", int'(pause), 0);
        chk("reset_dim", int'(dim_level), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Running, no buttons: pass-through, never dims.
        tick(1000);
        chk("run_dim", int'(dim_level), 0);
        chk("run_r", int'(vif.r_out), 7);
        chk("run_b", int'(vif.b_out), 3);

        // User pause, dim levels, unpause.
        pulse_pause();
        tick(2);
        chk("pause_on", int'(pause), 1);
        tick(103);
        chk("dim1", int'(dim_level), 1);
        chk("dim1_rgb", int'({vif.r_out, vif.g_out, vif.b_out}), int'({3'd3, 3'd2, 2'd1}));
        tick(25);
        chk("dim2", int'(dim_level), 2);
        chk("dim2_rgb", int'({vif.r_out, vif.g_out, vif.b_out}), int'({3'd1, 3'd1, 2'd0}));
        pulse_pause();
        tick(2);
        chk("unpause", int'(pause), 0);
        chk("undim_rgb", int'({vif.r_out, vif.g_out, vif.b_out}), int'({3'd7, 3'd5, 2'd3}));

        // External hold while running.
        hold_req = 2'b10;
        tick(500);
        chk("hold_pause", int'(pause), 1);
        chk("hold_dim", int'(dim_level), 0);
        chk("hold_user", int'(user_paused), 0);
        hold_req = 2'b00;
        tick(1);
        chk("hold_release", int'(pause), 0);

        // Single-frame step.
        pulse_pause();
        tick(4);
        pulse_step();
        tick(3);
        chk("step_run", int'(pause), 0);
        chk("step_user", int'(user_paused), 1);
        vif.vblank = 1'b1;
        tick(3);
        vif.vblank = 1'b0;
        chk("step_done", int'(pause), 1);
        pulse_pause();
        tick(3);
        pulse_step();
        tick(4);
        chk("step_in_run", int'(user_paused), 0);

        // OSD auto-pause and dim disable.
        cfg_osd_pause = 1'b1; osd_status = 1'b1;
        tick(2);
        chk("osd_pause", int'(pause), 1);
        tick(120);
        chk("osd_dim", int'(dim_level), 2);
        cfg_dim_en = 1'b0;
        tick(1);
        chk("dim_off", int'(dim_level), 0);
        cfg_dim_en = 1'b1;

        // Reset in STEP while dimmed.
        tick(115);
        pulse_pause();
        tick(3);
        pulse_step();
        tick(3);
        chk("pre_rst_user", int'(user_paused), 1);
        chk("pre_rst_dim", int'(dim_level), 2);
        reset_n = 1'b0;
        #1;
        chk("async_rst", int'({pause, user_paused, dim_level, vif.r_out, vif.g_out, vif.b_out}), 0);
        osd_status = 1'b0; cfg_osd_pause = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        chk("post_rst_pause", int'(pause), 0);
        chk("post_rst_user", int'(user_paused), 0);

        // Randomised traffic against the model.
        for (int c = 0; c < 6000; c++) begin
            vif.r_in = 3'($urandom);
            vif.g_in = 3'($urandom);
            vif.b_in = 2'($urandom);
            pause_btn = ($urandom_range(0, 299) == 0);
            step_btn  = ($urandom_range(0, 59) == 0);
            vif.vblank = ((c % 40) < 6);
            if ($urandom_range(0, 149) == 0) hold_req = 2'($urandom);
            if ($urandom_range(0, 399) == 0) osd_status = ~osd_status;
            if ($urandom_range(0, 399) == 0) cfg_osd_pause = 1'($urandom);
            if ($urandom_range(0, 499) == 0) cfg_dim_en = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
